adam_jtag_dtm: RTL and testbench

ADAM_JTAG_DTM -- requirements
Module: adam_jtag_dtm

---
 rtl/adam_pkg.sv | 44 ++++
 rtl/adam_jtag_tap.sv | 66 ++++++
 rtl/adam_jtag_dtm.sv | 159 +++++++++++++++
 tb/tb_adam_jtag_dtm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adam_pkg.sv
// Shared encodings for the ADAM JTAG debug transport: TAP states, IR codes,
// DMI status/op values and DTMCS field layout.
package adam_pkg;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

  localparam int         IR_W       = 5;
  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DTMCS   = 5'h10;
  localparam logic [4:0] IR_DMI     = 5'h11;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  typedef enum logic [1:0] {
    DMI_OK = 2'd0, DMI_RSVD = 2'd1, DMI_FAILED = 2'd2, DMI_BUSY = 2'd3
  } dmistat_e;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam int DTMCS_VER_LSB   = 0;
  localparam int DTMCS_ABITS_LSB = 4;
  localparam int DTMCS_STAT_LSB  = 10;
  localparam int DTMCS_IDLE_LSB  = 12;
  localparam int DTMCS_DMIRESET  = 16;
  localparam int DTMCS_HARDRESET = 17;

  function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                             input logic [1:0] stat,
                                             input logic [5:0] abits);
    logic [31:0] w;
    w = '0;
    w[DTMCS_VER_LSB   +: 4] = 4'd1;
    w[DTMCS_ABITS_LSB +: 6] = abits;
    w[DTMCS_STAT_LSB  +: 2] = stat;
    w[DTMCS_IDLE_LSB  +: 3] = idle;
    return w;
  endfunction

endpackage

// File: rtl/adam_jtag_tap.sv
// IEEE 1149.1 TAP controller plus 5-bit instruction register, stepped by
// detected TCK rising edges in the system clock domain.
module adam_jtag_tap import adam_pkg::*; (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tck_rise,
  input  logic            i_tms,
  input  logic            i_tdi,
  output tap_state_e      o_state,
  output logic [IR_W-1:0] o_ir,
  output logic            o_ir_tdo
);

  tap_state_e      r_state, w_next;
  logic [IR_W-1:0] r_ir, r_ir_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst)           r_state <= TAP_TLR;
    else if (i_tck_rise) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TAP_TLR:    w_next = i_tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: w_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: w_next = i_tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  w_next = i_tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: w_next = i_tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: w_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: w_next = i_tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  w_next = i_tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: w_next = i_tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      default:    w_next = TAP_TLR;
    endcase
  end

  // Capture/shift/update all act on the rise that leaves the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else if (r_state == TAP_TLR) begin
      r_ir <= IR_IDCODE;
    end else if (i_tck_rise) begin
      case (r_state)
        TAP_CAP_IR: r_ir_sr <= IR_CAPTURE;
        TAP_SH_IR:  r_ir_sr <= {i_tdi, r_ir_sr[IR_W-1:1]};
        TAP_UPD_IR: r_ir    <= r_ir_sr;
        default: ;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_ir     = r_ir;
  assign o_ir_tdo = r_ir_sr[0];

endmodule

// File: rtl/adam_jtag_dtm.sv
// JTAG debug transport module: oversampled JTAG pins, IDCODE/DTMCS/DMI/BYPASS
// data registers and the DMI request/response handshake.
module adam_jtag_dtm import adam_pkg::*; #(
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  parameter int          ABITS  = 7,
  parameter int          IDLE   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tck,
  input  logic             i_tms,
  input  logic             i_tdi,
  output logic             o_tdo,
  output logic             o_dmi_req_valid,
  input  logic             i_dmi_req_ready,
  output logic [ABITS-1:0] o_dmi_req_addr,
  output logic [31:0]      o_dmi_req_data,
  output logic [1:0]       o_dmi_req_op,
  input  logic             i_dmi_rsp_valid,
  output logic             o_dmi_rsp_ready,
  input  logic [31:0]      i_dmi_rsp_data,
  input  logic [1:0]       i_dmi_rsp_resp
);

  localparam int DMI_W = ABITS + 34;

  logic [1:0]       r_tck_s, r_tms_s, r_tdi_s;
  logic             r_tck_q, r_tdo;
  logic             w_tck_rise, w_tck_fall, w_tms, w_tdi, w_ir_tdo, w_rsp_hs;
  tap_state_e       w_state;
  logic [IR_W-1:0]  w_ir;
  logic [31:0]      w_dtmcs;
  logic [DMI_W-1:0] r_dr;
  dmistat_e         r_dmistat;
  logic [ABITS-1:0] r_last_addr, r_req_addr;
  logic [31:0]      r_last_data, r_req_data;
  logic [1:0]       r_req_op;
  logic             r_req_valid, r_busy;
  logic [ABITS-1:0] w_upd_addr;
  logic [31:0]      w_upd_data;
  logic [1:0]       w_upd_op;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tck_s <= '0;
      r_tms_s <= '0;
      r_tdi_s <= '0;
      r_tck_q <= 1'b0;
    end else begin
      r_tck_s <= {r_tck_s[0], i_tck};
      r_tms_s <= {r_tms_s[0], i_tms};
      r_tdi_s <= {r_tdi_s[0], i_tdi};
      r_tck_q <= r_tck_s[1];
    end
  end

  assign w_tck_rise = r_tck_s[1] & ~r_tck_q;
  assign w_tck_fall = ~r_tck_s[1] & r_tck_q;
  assign w_tms      = r_tms_s[1];
  assign w_tdi      = r_tdi_s[1];

  adam_jtag_tap u_tap (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tck_rise (w_tck_rise),
    .i_tms      (w_tms),
    .i_tdi      (w_tdi),
    .o_state    (w_state),
    .o_ir       (w_ir),
    .o_ir_tdo   (w_ir_tdo)
  );

  assign w_dtmcs    = dtmcs_word(3'(IDLE), r_dmistat, 6'(ABITS));
  assign w_upd_addr = r_dr[DMI_W-1 -: ABITS];
  assign w_upd_data = r_dr[33:2];
  assign w_upd_op   = r_dr[1:0];
  assign w_rsp_hs   = r_busy & i_dmi_rsp_valid;

  // Response handling comes first so a same-cycle DTMCS reset overrides it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dr        <= '0;
      r_dmistat   <= DMI_OK;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= OP_NOP;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (r_req_valid && i_dmi_req_ready) r_req_valid <= 1'b0;
      if (w_rsp_hs) begin
        r_busy      <= 1'b0;
        r_last_data <= i_dmi_rsp_data;
        if (i_dmi_rsp_resp != 2'd0 && r_dmistat == DMI_OK) r_dmistat <= DMI_FAILED;
      end
      if (w_tck_rise) begin
        case (w_state)
          TAP_CAP_DR: begin
            case (w_ir)
              IR_IDCODE: r_dr <= DMI_W'({IDCODE[31:1], 1'b1});
              IR_DTMCS:  r_dr <= DMI_W'(w_dtmcs);
              IR_DMI: begin
                r_dr <= {r_last_addr, r_last_data, (r_busy ? DMI_BUSY : r_dmistat)};
                if (r_busy) r_dmistat <= DMI_BUSY;
              end
              default:   r_dr <= '0;
            endcase
          end
          TAP_SH_DR: begin
            case (w_ir)
              IR_IDCODE, IR_DTMCS: r_dr[31:0] <= {w_tdi, r_dr[31:1]};
              IR_DMI:              r_dr <= {w_tdi, r_dr[DMI_W-1:1]};
              default:             r_dr[0] <= w_tdi;
            endcase
          end
          TAP_UPD_DR: begin
            if (w_ir == IR_DTMCS) begin
              if (r_dr[DTMCS_HARDRESET]) begin
                r_dmistat   <= DMI_OK;
                r_busy      <= 1'b0;
                r_req_valid <= 1'b0;
              end else if (r_dr[DTMCS_DMIRESET]) begin
                r_dmistat <= DMI_OK;
              end
            end else if (w_ir == IR_DMI) begin
              if (r_busy) begin
                r_dmistat <= DMI_BUSY;
              end else if (r_dmistat == DMI_OK && (w_upd_op == OP_READ || w_upd_op == OP_WRITE)) begin
                r_req_valid <= 1'b1;
                r_busy      <= 1'b1;
                r_req_addr  <= w_upd_addr;
                r_req_data  <= w_upd_data;
                r_req_op    <= w_upd_op;
                r_last_addr <= w_upd_addr;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)           r_tdo <= 1'b0;
    else if (w_tck_fall) r_tdo <= (w_state == TAP_SH_IR) ? w_ir_tdo :
                                  (w_state == TAP_SH_DR) ? r_dr[0] : 1'b0;
  end

  assign o_tdo           = r_tdo;
  assign o_dmi_req_valid = r_req_valid;
  assign o_dmi_req_addr  = r_req_addr;
  assign o_dmi_req_data  = r_req_data;
  assign o_dmi_req_op    = r_req_op;
  assign o_dmi_rsp_ready = r_busy;

endmodule

// File: tb/tb_adam_jtag_dtm.sv
// Scoreboard bench for adam_jtag_dtm: scans and DMI requests push expectations
// into queues that independent monitors drain and compare.
module tb_adam_jtag_dtm;
  localparam int ABITS = 7;
  localparam int HALF  = 8;

  logic clk = 0, rst = 1, tck = 0, tms = 1, tdi = 0, tdo;
  logic req_valid, req_ready = 1, rsp_valid = 0, rsp_ready;
  logic [ABITS-1:0] req_addr;
  logic [31:0] req_data, rsp_data = '0, nxt_data = '0;
  logic [1:0]  req_op, rsp_resp = '0, nxt_resp = '0;
  int n_vec = 0, n_err = 0;

  string       exp_name_q[$];
  logic [63:0] exp_val_q[$];
  logic [63:0] got_q[$];
  logic [40:0] exp_req_q[$];

  always #5 clk = ~clk;

  adam_jtag_dtm #(.IDCODE(32'h0BEE_F001), .ABITS(ABITS), .IDLE(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_tck(tck), .i_tms(tms), .i_tdi(tdi), .o_tdo(tdo),
    .o_dmi_req_valid(req_valid), .i_dmi_req_ready(req_ready),
    .o_dmi_req_addr(req_addr), .o_dmi_req_data(req_data), .o_dmi_req_op(req_op),
    .i_dmi_rsp_valid(rsp_valid), .o_dmi_rsp_ready(rsp_ready),
    .i_dmi_rsp_data(rsp_data), .i_dmi_rsp_resp(rsp_resp)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] dw(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // tdo sampled late in the low phase, just before the rise that shifts.
  task automatic tck_pulse(input logic t_ms, input logic t_di, output logic t_do);
    tms = t_ms;
    tdi = t_di;
    tick(HALF);
    t_do = tdo;
    tck = 1;
    tick(HALF);
    tck = 0;
  endtask

  task automatic scan_ir(input logic [4:0] code, input string nm);
    logic b;
    logic [63:0] got;
    got = '0;
    exp_name_q.push_back(nm);
    exp_val_q.push_back(64'h1);
    tck_pulse(1, 0, b); tck_pulse(1, 0, b); tck_pulse(0, 0, b); tck_pulse(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      tck_pulse(i == 4, code[i], b);
      got[i] = b;
    end
    tck_pulse(1, 0, b); tck_pulse(0, 0, b);
    got_q.push_back(got);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, input string nm, input logic [63:0] exp);
    logic b;
    logic [63:0] got;
    got = '0;
    exp_name_q.push_back(nm);
    exp_val_q.push_back(exp);
    tck_pulse(1, 0, b); tck_pulse(0, 0, b); tck_pulse(0, 0, b);
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], b);
      got[i] = b;
    end
    tck_pulse(1, 0, b); tck_pulse(0, 0, b);
    got_q.push_back(got);
  endtask

  initial begin : scan_monitor
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        logic [63:0] g;
        g = got_q.pop_front();
        if (exp_val_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scan_unexpected: got %h expected none", g);
        end else begin
          check(exp_name_q.pop_front(), g, exp_val_q.pop_front());
        end
      end
    end
  end

  initial begin : req_monitor
    forever begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dmi_req_unexpected: got %h expected none", {req_addr, req_data, req_op});
        end else begin
          check("dmi_req", 64'({req_addr, req_data, req_op}), 64'(exp_req_q.pop_front()));
        end
      end
    end
  end

  initial begin : responder
    forever begin
      @(negedge clk);
      if (req_valid && req_ready && !rst) begin
        tick(3);
        rsp_data  = nxt_data;
        rsp_resp  = nxt_resp;
        rsp_valid = 1;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (rsp_ready) break;
        end
        tick(1);
        rsp_valid = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic b;
    tick(5);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_req_valid", 64'(req_valid), 64'h0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'h0);
    rst = 0;
    tick(2);
    tck_pulse(0, 0, b);
    scan_dr(32, 64'h0, "idcode", 64'h0BEE_F001);

    scan_ir(5'h10, "ir_cap_dtmcs");
    scan_dr(32, 64'h0, "dtmcs", 64'h1071);

    scan_ir(5'h11, "ir_cap_dmi");
    nxt_data = 32'hCAFE_0001; nxt_resp = 2'd0;
    exp_req_q.push_back({7'h10, 32'h1, 2'd2});
    scan_dr(41, dw(7'h10, 32'h1, 2'd2), "dmi_wr_cap", 64'h0);
    tck_pulse(0, 0, b);
    nxt_data = 32'h1234_5678;
    exp_req_q.push_back({7'h10, 32'h0, 2'd1});
    scan_dr(41, dw(7'h10, 32'h0, 2'd1), "dmi_rd_cap", dw(7'h10, 32'hCAFE_0001, 2'd0));
    scan_dr(41, 64'h0, "dmi_rd_data", dw(7'h10, 32'h1234_5678, 2'd0));

    req_ready = 0;
    scan_dr(41, dw(7'h20, 32'hAA, 2'd2), "dmi_wr2_cap", dw(7'h10, 32'h1234_5678, 2'd0));
    tick(200);
    scan_dr(41, 64'h0, "dmi_busy_cap", dw(7'h20, 32'h1234_5678, 2'd3));
    scan_dr(41, dw(7'h21, 32'hBB, 2'd2), "dmi_busy_wr", dw(7'h20, 32'h1234_5678, 2'd3));
    scan_ir(5'h10, "ir_cap_dtmcs2");
    scan_dr(32, 64'h1_0000, "dtmcs_busy", 64'h1C71);
    scan_dr(32, 64'h0, "dtmcs_cleared", 64'h1071);

    nxt_data = 32'hDEAD_BEEF; nxt_resp = 2'd2;
    exp_req_q.push_back({7'h20, 32'hAA, 2'd2});
    req_ready = 1;
    tick(20);
    scan_ir(5'h11, "ir_cap_dmi2");
    scan_dr(41, dw(7'h30, 32'h5, 2'd2), "dmi_fail_cap", dw(7'h20, 32'hDEAD_BEEF, 2'd2));
    scan_dr(41, 64'h0, "dmi_fail_sticky", dw(7'h20, 32'hDEAD_BEEF, 2'd2));
    scan_ir(5'h10, "ir_cap_dtmcs3");
    scan_dr(32, 64'h1_0000, "dtmcs_fail", 64'h1871);
    scan_ir(5'h11, "ir_cap_dmi3");
    nxt_data = 32'h0; nxt_resp = 2'd0;
    exp_req_q.push_back({7'h30, 32'h5, 2'd2});
    scan_dr(41, dw(7'h30, 32'h5, 2'd2), "dmi_unblock_cap", dw(7'h20, 32'hDEAD_BEEF, 2'd0));
    scan_dr(41, 64'h0, "dmi_unblock_data", dw(7'h30, 32'h0, 2'd0));

    // Park in Shift-DR, then five TMS-high clocks must land in Test-Logic-Reset.
    tck_pulse(1, 0, b); tck_pulse(0, 0, b); tck_pulse(0, 0, b);
    for (int i = 0; i < 5; i++) tck_pulse(1, 0, b);
    tck_pulse(0, 0, b);
    scan_dr(32, 64'h0, "idcode_after_tlr", 64'h0BEE_F001);

    scan_ir(5'h11, "ir_cap_dmi4");
    req_ready = 0;
    scan_dr(41, dw(7'h40, 32'h7, 2'd2), "dmi_pre_rst_cap", dw(7'h30, 32'h0, 2'd0));
    tick(5);
    check("req_valid_pending", 64'(req_valid), 64'h1);
    rst = 1;
    tick(1);
    check("req_valid_after_rst", 64'(req_valid), 64'h0);
    rst = 0;
    req_ready = 1;
    tick(30);
    tck_pulse(0, 0, b);
    scan_dr(32, 64'h0, "idcode_after_rst", 64'h0BEE_F001);

    tick(20);
    n_vec++;
    if (exp_val_q.size() != 0) begin
      n_err++;
      $display("FAIL scan_lost: got %0d pending expected 0", exp_val_q.size());
    end
    n_vec++;
    if (exp_req_q.size() != 0) begin
      n_err++;
      $display("FAIL req_missing: got %0d pending expected 0", exp_req_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
